// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, single-step shifts
// and counted multi-cycle shifts sequenced by a small FSM.
module univ_shift_reg #(
  parameter int DATA_WIDTH = 24,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst_N,
  input  logic                  in_Load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_En,
  input  logic                  in_Dir,
  input  logic                  in_Arith,
  input  logic                  in_shift_in,
  input  logic                  in_Start,
  input  logic [CNT_WIDTH-1:0]  in_Amount,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_shift_out,
  output logic                  out_Busy,
  output logic                  out_Done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  so_q, so_n;
  logic [CNT_WIDTH-1:0]  cnt, cnt_n;
  logic                  dir_q, dir_n;
  logic                  arith_q, arith_n;

  logic                  use_dir;
  logic                  use_arith;
  logic [DATA_WIDTH-1:0] step_data;
  logic                  step_so;
  logic                  msb_fill;

  // Counted shifts use the direction latched at Start, single steps the live one
  assign use_dir   = (state == SHIFT) ? dir_q   : in_Dir;
  assign use_arith = (state == SHIFT) ? arith_q : in_Arith;
  assign msb_fill  = use_arith ? data_q[DATA_WIDTH-1] : in_shift_in;

  always_comb begin
    step_data = data_q;
    step_so   = so_q;
    if (use_dir) begin
      step_data = {msb_fill, data_q[DATA_WIDTH-1:1]};
      step_so   = data_q[0];
    end else begin
      step_data = {data_q[DATA_WIDTH-2:0], in_shift_in};
      step_so   = data_q[DATA_WIDTH-1];
    end
  end

  always_comb begin
    state_n = state;
    data_n  = data_q;
    so_n    = so_q;
    cnt_n   = cnt;
    dir_n   = dir_q;
    arith_n = arith_q;
    unique case (state)
      IDLE: begin
        if (in_Load) begin
          data_n = in_data;
        end else if (in_Start) begin
          cnt_n   = in_Amount;
          dir_n   = in_Dir;
          arith_n = in_Arith;
          state_n = (in_Amount != '0) ? SHIFT : DONE;
        end else if (in_En) begin
          data_n = step_data;
          so_n   = step_so;
        end
      end
      SHIFT: begin
        data_n = step_data;
        so_n   = step_so;
        cnt_n  = cnt - 1'b1;
        if (cnt == CNT_WIDTH'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state   <= IDLE;
      data_q  <= '0;
      so_q    <= 1'b0;
      cnt     <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      state   <= state_n;
      data_q  <= data_n;
      so_q    <= so_n;
      cnt     <= cnt_n;
      dir_q   <= dir_n;
      arith_q <= arith_n;
    end
  end

  assign out_data      = data_q;
  assign out_shift_out = so_q;
  assign out_Busy      = (state == SHIFT);
  assign out_Done      = (state == DONE);

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, meaning register width in bits (>= 2).
REQ-002 SHALL have parameter CNT_WIDTH, default 5, meaning width of shift-amount input and internal counter.
REQ-003 SHALL have port in_Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port in_Rst_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_Load, input, 1, parallel load request.
REQ-006 SHALL have port in_data, input, DATA_WIDTH, parallel load value.
REQ-007 SHALL have port in_En, input, 1, single-step shift enable.
REQ-008 SHALL have port in_Dir, input, 1, direction: 0 = left, 1 = right.
REQ-009 SHALL have port in_Arith, input, 1, arithmetic mode; right shifts only.
REQ-010 SHALL have port in_shift_in, input, 1, serial fill bit.
REQ-011 SHALL have port in_Start, input, 1, counted multi-cycle shift request.
REQ-012 SHALL have port in_Amount, input, CNT_WIDTH, number of 1-bit shifts for a counted shift.
REQ-013 SHALL have port out_data, output, DATA_WIDTH, registered contents.
REQ-014 SHALL have port out_shift_out, output, 1, registered copy of the last bit shifted out.
REQ-015 SHALL have port out_Busy, output, 1, high while in SHIFT.
REQ-016 SHALL have port out_Done, output, 1, one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, SHIFT, DONE; out_Busy = (state==SHIFT), out_Done = (state==DONE), both decoded from registered state.
REQ-018 One shift step: left -> data<<1, bit0 = in_shift_in, shift_out = old MSB; right logical -> data>>1, MSB = in_shift_in, shift_out = old bit0; right arithmetic -> MSB = old MSB, in_shift_in ignored.
REQ-019 Left shift SHALL ignore in_Arith.
REQ-020 IDLE priority SHALL be in_Load > in_Start > in_En; lower-priority requests in the same cycle are dropped.
REQ-021 IDLE, in_Load: out_data <= in_data; out_shift_out unchanged; stay IDLE.
REQ-022 IDLE, in_En (no Load/Start): one step per REQ-018 using current in_Dir/in_Arith; stay IDLE.
REQ-023 IDLE, in_Start: latch in_Amount into counter, latch in_Dir and in_Arith; no data change that edge; go SHIFT if in_Amount != 0, else go DONE.
REQ-024 SHIFT: each edge perform one step using latched Dir/Arith and live in_shift_in; decrement counter; on the step where counter == 1 go DONE.
REQ-025 Latency: Start sampled at edge t with Amount N>0 -> shifts at edges t+1..t+N, out_Done high for exactly the cycle after edge t+N; N=0 -> out_Done high for the cycle after edge t.
REQ-026 SHIFT and DONE SHALL ignore in_Load, in_Start, in_En, in_Dir, in_Arith, in_Amount.
REQ-027 DONE SHALL last one cycle, then return to IDLE unconditionally; data held.
REQ-028 in_Amount > DATA_WIDTH SHALL be executed literally (N steps, register filled entirely with fill bits).
REQ-029 Without a qualifying request, out_data and out_shift_out SHALL hold.

Reset
REQ-030 in_Rst_N low SHALL immediately force out_data = 0, out_shift_out = 0, counter = 0, latched Dir/Arith = 0, state = IDLE (out_Busy = 0, out_Done = 0), including mid-SHIFT.
REQ-031 After release, first rising edge SHALL behave as IDLE.

Verification (DATA_WIDTH = 8)
REQ-032 Assert reset mid-SHIFT -> all outputs 0 asynchronously, no Done pulse, IDLE after release.
REQ-033 Load 0xA5; En, Dir=0, shift_in=1 -> out_data = 0x4B, out_shift_out = 1.
REQ-034 Load 0x96; Start, Amount=3, Dir=1, Arith=1 -> Busy high 3 cycles, out_data = 0xF2, out_shift_out = 1, Done high 1 cycle.
REQ-035 Load 0x96; Start, Amount=3, Dir=1, Arith=0, shift_in=0 -> out_data = 0x12, Done after third shift.
REQ-036 Start, Amount=0 -> Busy never high, Done next cycle, out_data unchanged.
REQ-037 During SHIFT pulse Load=1 (in_data=0xFF), Start=1 -> ignored; result identical to REQ-034; Load+En together in IDLE -> load only.
